// File: rtl/carry_skip_adder_pipe.sv
// Pipelined carry-skip adder/subtractor: one BLK-bit skip block per stage,
// valid/ready handshake with a single global advance, all outputs registered.
module carry_skip_adder_pipe #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned BLK   = 4
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [WIDTH-1:0]                    a,
  input  logic [WIDTH-1:0]                    b,
  input  logic                                cin,
  input  logic                                sub,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [WIDTH-1:0]                    sum,
  output logic                                cout,
  output logic                                ovf,
  output logic [$clog2(WIDTH/BLK+1)-1:0]      skip_cnt
);

  localparam int unsigned NBLK = WIDTH / BLK;
  localparam int unsigned CW   = $clog2(NBLK + 1);

  logic adv;
  logic [WIDTH-1:0] b_eff;
  logic c_eff;

  // stage registers, one entry per skip block
  logic [NBLK-1:0][WIDTH-1:0] r_a, r_b, r_sum;
  logic [NBLK-1:0][CW-1:0]    r_cnt;
  logic [NBLK-1:0]            r_c, r_v;
  logic                       r_ovf;

  // stage inputs (stage 0 from the ports, stage k from stage k-1)
  logic [NBLK-1:0][WIDTH-1:0] src_a, src_b, src_sum;
  logic [NBLK-1:0][CW-1:0]    src_cnt;
  logic [NBLK-1:0]            src_c, src_v;

  logic [NBLK-1:0][WIDTH-1:0] nxt_sum;
  logic [NBLK-1:0][CW-1:0]    nxt_cnt;
  logic [NBLK-1:0]            nxt_c;
  logic                       nxt_ovf;

  logic unused_last_opr;

  assign adv      = !r_v[NBLK-1] || out_ready;
  assign in_ready = adv;
  assign b_eff    = sub ? ~b : b;
  assign c_eff    = sub | cin;

  // last stage keeps its operands only for uniformity; nothing downstream reads them
  assign unused_last_opr = ^{r_a[NBLK-1], r_b[NBLK-1]};

  always_comb begin
    src_a   = '0;
    src_b   = '0;
    src_sum = '0;
    src_cnt = '0;
    src_c   = '0;
    src_v   = '0;
    src_a[0] = a;
    src_b[0] = b_eff;
    src_c[0] = c_eff;
    src_v[0] = in_valid;
    for (int unsigned k = 1; k < NBLK; k++) begin
      src_a[k]   = r_a[k-1];
      src_b[k]   = r_b[k-1];
      src_sum[k] = r_sum[k-1];
      src_cnt[k] = r_cnt[k-1];
      src_c[k]   = r_c[k-1];
      src_v[k]   = r_v[k-1];
    end
  end

  // per-block ripple; the block carry-out bypasses the ripple when the block fully propagates
  always_comb begin
    logic [BLK:0]   blk;
    logic [BLK-1:0] prop;
    logic           p;
    blk     = '0;
    prop    = '0;
    p       = 1'b0;
    nxt_sum = src_sum;
    nxt_cnt = '0;
    nxt_c   = '0;
    for (int unsigned k = 0; k < NBLK; k++) begin
      blk  = {1'b0, src_a[k][k*BLK +: BLK]} + {1'b0, src_b[k][k*BLK +: BLK]}
           + (BLK+1)'(src_c[k]);
      prop = src_a[k][k*BLK +: BLK] ^ src_b[k][k*BLK +: BLK];
      p    = &prop;
      nxt_sum[k][k*BLK +: BLK] = blk[BLK-1:0];
      nxt_c[k]   = p ? src_c[k] : blk[BLK];
      nxt_cnt[k] = src_cnt[k] + CW'(p);
    end
    nxt_ovf = (src_a[NBLK-1][WIDTH-1] == src_b[NBLK-1][WIDTH-1]) &&
              (nxt_sum[NBLK-1][WIDTH-1] != src_a[NBLK-1][WIDTH-1]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a   <= '0;
      r_b   <= '0;
      r_sum <= '0;
      r_cnt <= '0;
      r_c   <= '0;
      r_v   <= '0;
      r_ovf <= 1'b0;
    end else if (adv) begin
      r_a   <= src_a;
      r_b   <= src_b;
      r_sum <= nxt_sum;
      r_cnt <= nxt_cnt;
      r_c   <= nxt_c;
      r_v   <= src_v;
      r_ovf <= nxt_ovf;
    end
  end

  assign out_valid = r_v[NBLK-1];
  assign sum       = r_sum[NBLK-1];
  assign cout      = r_c[NBLK-1];
  assign skip_cnt  = r_cnt[NBLK-1];
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_carry_skip_adder_pipe.sv
// Scoreboard bench for carry_skip_adder_pipe: three configurations (16/4, 8/2, 32/8,
// all four stages deep) share one handshake and are checked against an arithmetic model.
module tb_carry_skip_adder_pipe;

  typedef struct packed {
    logic [31:0] s;
    logic        c;
    logic        o;
    logic [7:0]  k;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n, in_valid, out_ready, cin, sub;
  logic [15:0] a16, b16;
  logic [7:0]  a8, b8;
  logic [31:0] a32, b32;
  logic ir16, ir8, ir32, ov16, ov8, ov32, co16, co8, co32, of16, of8, of32;
  logic [15:0] s16;
  logic [7:0]  s8;
  logic [31:0] s32;
  logic [2:0]  k16, k8, k32;

  exp_t got16, got8, got32, snap;
  exp_t q16[$], q8[$], q32[$];
  int   qacc[$];
  int   checks = 0, errors = 0, cyc = 0, n_acc = 0;
  bit   chk_lat = 1'b0, hold_pend = 1'b0;

  always #5 clk = ~clk;

  carry_skip_adder_pipe #(.WIDTH(16), .BLK(4)) d16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir16), .a(a16), .b(b16),
    .cin(cin), .sub(sub), .out_valid(ov16), .out_ready(out_ready), .sum(s16),
    .cout(co16), .ovf(of16), .skip_cnt(k16));
  carry_skip_adder_pipe #(.WIDTH(8), .BLK(2)) d8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir8), .a(a8), .b(b8),
    .cin(cin), .sub(sub), .out_valid(ov8), .out_ready(out_ready), .sum(s8),
    .cout(co8), .ovf(of8), .skip_cnt(k8));
  carry_skip_adder_pipe #(.WIDTH(32), .BLK(8)) d32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir32), .a(a32), .b(b32),
    .cin(cin), .sub(sub), .out_valid(ov32), .out_ready(out_ready), .sum(s32),
    .cout(co32), .ovf(of32), .skip_cnt(k32));

  assign got16 = {32'(s16), co16, of16, 8'(k16)};
  assign got8  = {32'(s8),  co8,  of8,  8'(k8)};
  assign got32 = {s32,      co32, of32, 8'(k32)};

  // Reference: plain (w+1)-bit addition; skip count = blocks whose a^b_eff bits are all ones
  function automatic exp_t model(input int unsigned w, input int unsigned blk,
                                 input logic [31:0] ai, input logic [31:0] bi,
                                 input logic ci, input logic sb);
    logic [31:0] mask, aa, bb, x, bm;
    logic [32:0] full;
    exp_t r;
    mask = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    aa   = ai & mask;
    bb   = (sb ? ~bi : bi) & mask;
    full = 33'(aa) + 33'(bb) + 33'(sb ? 1'b1 : ci);
    r.s  = full[31:0] & mask;
    r.c  = full[w];
    r.o  = (aa[w-1] == bb[w-1]) && (r.s[w-1] != aa[w-1]);
    x    = aa ^ bb;
    bm   = (32'd1 << blk) - 32'd1;
    r.k  = 8'd0;
    for (int unsigned i = 0; i < w / blk; i++)
      if (((x >> (i * blk)) & bm) == bm) r.k = r.k + 8'd1;
    return r;
  endfunction

  function automatic logic [31:0] rop();
    case ($urandom_range(6))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h7FFF_FFFF;
      3: return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h", nm, got, want);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pops and compares on every output transfer, pushes on every input transfer
  always @(negedge clk) begin
    if (!rst_n) begin
      q16.delete(); q8.delete(); q32.delete(); qacc.delete();
      hold_pend <= 1'b0;
    end else begin
      chk("valid_sync", 64'({ov8, ov32}), 64'({ov16, ov16}));
      chk("ready_sync", 64'({ir8, ir32}), 64'({ir16, ir16}));
      chk("in_ready", 64'(ir16), 64'(!ov16 || out_ready));
      if (hold_pend) chk("hold", 64'({ov16, got16}), 64'({1'b1, snap}));
      if (ov16 && out_ready) begin
        if (q16.size() == 0) begin
          checks++; errors++;
          $display("FAIL stale_output got=%h want=none", got16);
        end else begin
          chk("res16", 64'(got16), 64'(q16.pop_front()));
          chk("res8",  64'(got8),  64'(q8.pop_front()));
          chk("res32", 64'(got32), 64'(q32.pop_front()));
          if (chk_lat) chk("latency", 64'(cyc - qacc[0]), 64'd4);
          void'(qacc.pop_front());
        end
      end
      if (in_valid && ir16) begin
        q16.push_back(model(16, 4, 32'(a16), 32'(b16), cin, sub));
        q8.push_back(model(8, 2, 32'(a8), 32'(b8), cin, sub));
        q32.push_back(model(32, 8, a32, b32, cin, sub));
        qacc.push_back(cyc);
        n_acc <= n_acc + 1;
      end
      hold_pend <= ov16 && !out_ready;
      snap      <= got16;
    end
  end

  task automatic set_ops(input logic [31:0] av, input logic [31:0] bv, input logic ci,
                         input logic sb);
    a32 = av; b32 = bv; a16 = av[15:0]; b16 = bv[15:0]; a8 = av[7:0]; b8 = bv[7:0];
    cin = ci; sub = sb;
  endtask

  // Holds the operation on the inputs until it is accepted (bounded)
  task automatic send(input logic [31:0] av, input logic [31:0] bv, input logic ci,
                      input logic sb);
    bit took = 1'b0;
    int n = 0;
    set_ops(av, bv, ci, sb);
    in_valid = 1'b1;
    while (!took && n < 100) begin
      @(negedge clk);
      took = ir16;
      @(posedge clk);
      #1;
      n++;
    end
    if (!took) begin
      checks++; errors++;
      $display("FAIL send_timeout got=not_accepted want=accepted");
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while (q16.size() != 0 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (q16.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d want=0", q16.size());
    end
    repeat (6) @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    set_ops(32'h0, 32'h0, 1'b0, 1'b0);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #2;
    chk("rst_out", 64'({ov16, ov8, ov32, got16}), 64'd0);
    chk("rst_in_ready", 64'({ir16, ir8, ir32}), 64'h7);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;

    // Directed corner operations, back to back, no stall: fixed latency
    chk_lat = 1'b1;
    send(32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    send(32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1);
    send(32'h0000_7FFF, 32'h0000_0001, 1'b0, 1'b0);
    send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0);
    send(32'h8000_8080, 32'h0000_0000, 1'b0, 1'b1);
    drain();

    // Eight back-to-back operations with a six-cycle downstream stall
    chk_lat = 1'b0;
    fork
      for (int i = 0; i < 8; i++) send($urandom, $urandom, 1'($urandom), 1'($urandom));
      begin
        repeat (2) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (6) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();

    // Reset with operations in flight
    chk_lat = 1'b1;
    for (int i = 0; i < 5; i++) send($urandom, $urandom, 1'($urandom), 1'($urandom));
    #2 rst_n = 1'b0;
    #1 chk("rst_async", 64'({ov16, ov8, ov32, got16}), 64'd0);
    @(posedge clk);
    #1 chk("rst_hold", 64'({ov16, ov8, ov32}), 64'd0);
    #1 rst_n = 1'b1;
    send(32'h0000_1234, 32'h0000_0FFF, 1'b1, 1'b0);
    drain();

    // Random traffic with random in_valid / out_ready
    chk_lat = 1'b0;
    begin
      int n0 = n_acc;
      for (int c = 0; c < 60000 && (n_acc - n0) < 10000; c++) begin
        out_ready = ($urandom_range(3) != 0);
        in_valid  = ($urandom_range(3) != 0);
        a32 = rop(); b32 = rop();
        a16 = 16'(rop()); b16 = 16'(rop());
        a8  = 8'(rop());  b8  = 8'(rop());
        cin = 1'($urandom); sub = 1'($urandom);
        @(posedge clk);
        #1;
      end
      checks++;
      if ((n_acc - n0) < 10000) begin
        errors++;
        $display("FAIL random_count got=%0d want=10000", n_acc - n0);
      end
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
